// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// frame-format constants.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronises the raw line, samples each bit at mid-bit
// and emits a one-cycle strobe per good byte or a frame_error pulse.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] byte_data,
    output logic                      byte_strobe,
    output logic                      frame_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      rxd_meta;
    logic                      rxd_s;
    uart_rx_state_t            state;
    uart_rx_state_t            state_next;
    logic [CNT_W-1:0]          clk_cnt;
    logic [CNT_W-1:0]          clk_cnt_next;
    logic [2:0]                bit_cnt;
    logic [2:0]                bit_cnt_next;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [UART_DATA_BITS-1:0] shift_next;
    logic                      strobe_next;
    logic                      frame_error_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta    <= UART_IDLE_LEVEL;
            rxd_s       <= UART_IDLE_LEVEL;
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            byte_strobe <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rxd_meta    <= rxd;
            rxd_s       <= rxd_meta;
            state       <= state_next;
            clk_cnt     <= clk_cnt_next;
            bit_cnt     <= bit_cnt_next;
            shift_reg   <= shift_next;
            byte_strobe <= strobe_next;
            frame_error <= frame_error_next;
        end
    end

    always_comb begin
        state_next       = state;
        clk_cnt_next     = clk_cnt;
        bit_cnt_next     = bit_cnt;
        shift_next       = shift_reg;
        strobe_next      = 1'b0;
        frame_error_next = 1'b0;
        case (state)
            IDLE: begin
                if (rxd_s != UART_IDLE_LEVEL) begin
                    state_next   = START;
                    clk_cnt_next = '0;
                    bit_cnt_next = '0;
                end
            end
            // A start bit that is high again at its mid-point is a glitch.
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_next = '0;
                    state_next   = (rxd_s == UART_IDLE_LEVEL) ? IDLE : DATA;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_next = '0;
                    shift_next   = {rxd_s, shift_reg[UART_DATA_BITS-1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        state_next = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_next = '0;
                    if (rxd_s == UART_IDLE_LEVEL) begin
                        strobe_next = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        frame_error_next = 1'b1;
                        state_next       = WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            // Hold off until the line returns high so a break cannot retrigger.
            WAIT_HIGH: begin
                if (rxd_s == UART_IDLE_LEVEL) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign byte_data = shift_reg;

endmodule

// File: rtl/uart_rx_word.sv
// UART receive front end: packs four received bytes little-endian into a
// 32-bit word and holds it in a one-entry valid/ready buffer.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_error,
    output logic        overrun
);

    logic [UART_DATA_BITS-1:0] byte_data;
    logic                      byte_strobe;
    logic [1:0]                byte_cnt;
    logic [23:0]               asm_word;
    logic                      word_done;
    logic                      load;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .byte_data  (byte_data),
        .byte_strobe(byte_strobe),
        .frame_error(frame_error)
    );

    // A completing word may load while the current one drains in the same cycle.
    assign word_done = byte_strobe && (byte_cnt == 2'd3);
    assign load      = word_done && (!word_valid || word_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt   <= '0;
            asm_word   <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (frame_error) begin
                byte_cnt <= '0;
            end else if (byte_strobe) begin
                case (byte_cnt)
                    2'd0:    asm_word[7:0]   <= byte_data;
                    2'd1:    asm_word[15:8]  <= byte_data;
                    2'd2:    asm_word[23:16] <= byte_data;
                    default: asm_word        <= asm_word;
                endcase
                byte_cnt <= byte_cnt + 1'b1;
            end

            if (load) begin
                word_data  <= {byte_data, asm_word};
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            if (word_done && !load) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
